// File: rtl/csa_key_sched.sv
// CSA block-cipher key-schedule expander: streams NUM_ROUNDS round keys obtained
// by iterating the CSA 64-bit key bit permutation, one permutation per cycle.

module key_perm (
    input  logic [63:0] key_i,
    output logic [63:0] key_o
);
    // Destination (1-based) of each source bit; bits are numbered MSB-first within bytes, byte 0 = key_i[7:0].
    localparam logic [6:0] KP [64] = '{
        7'h12, 7'h24, 7'h09, 7'h07, 7'h2A, 7'h31, 7'h1D, 7'h15,
        7'h1C, 7'h36, 7'h3E, 7'h32, 7'h13, 7'h21, 7'h3B, 7'h40,
        7'h18, 7'h14, 7'h25, 7'h27, 7'h02, 7'h35, 7'h1B, 7'h01,
        7'h22, 7'h04, 7'h0D, 7'h0E, 7'h39, 7'h28, 7'h1A, 7'h29,
        7'h33, 7'h23, 7'h34, 7'h0C, 7'h16, 7'h30, 7'h1E, 7'h3A,
        7'h2D, 7'h1F, 7'h08, 7'h19, 7'h17, 7'h2F, 7'h3D, 7'h11,
        7'h3C, 7'h05, 7'h38, 7'h2B, 7'h0B, 7'h06, 7'h0A, 7'h2C,
        7'h20, 7'h3F, 7'h2E, 7'h0F, 7'h03, 7'h26, 7'h10, 7'h37
    };

    function automatic logic [63:0] permute(input logic [63:0] k);
        logic [63:0] r;
        logic [5:0]  s;
        logic [5:0]  d;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            s = 6'(j);
            d = 6'(KP[s] - 7'd1);
            r[{d[5:3], ~d[2:0]}] = k[{s[5:3], ~s[2:0]}];
        end
        return r;
    endfunction

    assign key_o = permute(key_i);
endmodule

module csa_key_sched #(
    parameter int unsigned NUM_ROUNDS = 7,
    parameter int unsigned ORDER      = 0,
    parameter int unsigned XOR_IDX    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] i_key,
    input  logic        i_key_valid,
    output logic        o_key_ready,
    input  logic        i_abort,
    output logic [63:0] o_rkey,
    output logic [3:0]  o_rkey_idx,
    output logic        o_rkey_last,
    output logic        o_rkey_valid,
    input  logic        i_rkey_ready
);
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned BUF_DEPTH = 16;
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = (ORDER == 0) ? '0 : TOP_IDX;

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [63:0]        work_q, work_d;
    logic [IDX_W-1:0]   gcnt_q, gcnt_d;
    logic [63:0]        rkey_q, rkey_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               kready_q, kready_d;
    logic [63:0]        perm_c;
    logic [IDX_W-1:0]   step_c;
    logic               buf_we_c;
    // Sized to the full 4-bit index range; only entries below NUM_ROUNDS are ever written.
    logic [63:0]        buf_q [BUF_DEPTH];

    function automatic logic [63:0] idx_mask(input logic [IDX_W-1:0] idx);
        return (XOR_IDX != 0) ? {8{4'h0, idx}} : 64'h0;
    endfunction

    key_perm u_key_perm (
        .key_i (work_q),
        .key_o (perm_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            gcnt_q   <= '0;
            rkey_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            kready_q <= 1'b1;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            gcnt_q   <= gcnt_d;
            rkey_q   <= rkey_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            kready_q <= kready_d;
            if (buf_we_c) begin
                buf_q[gcnt_q] <= work_q;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        gcnt_d   = gcnt_q;
        rkey_d   = rkey_q;
        idx_d    = idx_q;
        last_d   = last_q;
        valid_d  = valid_q;
        buf_we_c = 1'b0;
        step_c   = (ORDER == 0) ? idx_q - 4'd1 : idx_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                if (i_key_valid && kready_q) begin
                    work_d = i_key;
                    if (ORDER == 0) begin
                        state_d = S_OUT;
                        valid_d = 1'b1;
                        idx_d   = TOP_IDX;
                        rkey_d  = i_key ^ idx_mask(TOP_IDX);
                        last_d  = (TOP_IDX == LAST_IDX);
                    end else begin
                        state_d = S_GEN;
                        gcnt_d  = TOP_IDX;
                    end
                end
            end
            S_GEN: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    buf_we_c = 1'b1;
                    work_d   = perm_c;
                    gcnt_d   = gcnt_q - 4'd1;
                    if (gcnt_q == '0) begin
                        state_d = S_OUT;
                        valid_d = 1'b1;
                        idx_d   = '0;
                        rkey_d  = work_q ^ idx_mask('0);
                        last_d  = (LAST_IDX == '0);
                    end
                end
            end
            S_OUT: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (i_rkey_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = step_c;
                        last_d = (step_c == LAST_IDX);
                        if (ORDER == 0) begin
                            work_d = perm_c;
                            rkey_d = perm_c ^ idx_mask(step_c);
                        end else begin
                            rkey_d = buf_q[step_c] ^ idx_mask(step_c);
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        kready_d = (state_d == S_IDLE);
    end

    assign o_key_ready  = kready_q;
    assign o_rkey       = rkey_q;
    assign o_rkey_idx   = idx_q;
    assign o_rkey_last  = last_q;
    assign o_rkey_valid = valid_q;
endmodule
